uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//   UART transmit scheduler. Pops characters from a downstream FIFO and
//   serialises them as start / data (LSB first) / optional parity / one or
//   two stop bits. The frame configuration is captured once per frame in
//   FETCH, so configuration inputs may change freely mid-frame.
//   Back-to-back frames are separated only by the single FETCH clock.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_tx_en        enables fetching of new characters (current frame always
//                  completes)
//   i_div          bit period minus one, in clocks
//   i_parity_en    append a parity bit
//   i_parity_odd   1 = odd parity, 0 = even parity
//   i_stop2        1 = two stop bits, 0 = one stop bit
//   i_fifo_empty   downstream FIFO empty flag
//   i_fifo_data    FIFO read data, valid the cycle after o_fifo_rd_req
//   o_fifo_rd_req  one-cycle FIFO pop strobe
//   o_tx           registered serial line, idle high
//   o_busy         high whenever the FSM is not idle
//   o_done         one-cycle pulse in the last clock of each frame
// ---------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_en,
  input  logic [DIV_WIDTH-1:0]  i_div,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_stop2,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_req,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  // Bit counter is wide enough to index the last data bit; it stops at
  // LAST_BIT instead of wrapping.
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  state_e                state_q,  state_d;
  logic [DIV_WIDTH-1:0]  div_q,    div_d;
  logic [DIV_WIDTH-1:0]  cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic [BW-1:0]         bit_q,    bit_d;
  logic                  par_q,    par_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q,  stop2_d;
  logic                  tx_q,     tx_d;
  logic                  busy_q,   busy_d;

  logic bit_end;
  logic last_stop;
  logic can_fetch;
  logic rd_req;

  // Bit boundary: the down-counter has reached zero in a serialising state.
  assign bit_end   = (cnt_q == '0);
  assign last_stop = bit_end &&
                     (((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2));
  assign can_fetch = i_tx_en && !i_fifo_empty && !i_rst;
  // A pop is issued either from IDLE or in the last clock of a frame, which
  // chains the next frame with only the FETCH clock in between.
  assign rd_req    = can_fetch && ((state_q == S_IDLE) || last_stop);

  assign o_fifo_rd_req = rd_req;
  assign o_done        = last_stop;
  assign o_tx          = tx_q;
  assign o_busy        = busy_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (rd_req) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        // Capture the character and the whole frame configuration; the
        // counter is loaded from the live divisor since div_q is written on
        // this same edge.
        shift_d  = i_fifo_data;
        div_d    = i_div;
        cnt_d    = i_div;
        par_en_d = i_parity_en;
        par_d    = (^i_fifo_data) ^ i_parity_odd;
        stop2_d  = i_stop2;
        bit_d    = '0;
        state_d  = S_START;
        tx_d     = 1'b0;
      end

      default: begin
        if (!bit_end) begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end else begin
          cnt_d = div_q;
          case (state_q)
            S_START: begin
              state_d = S_DATA;
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
            end

            S_DATA: begin
              if (bit_q == LAST_BIT) begin
                if (par_en_q) begin
                  state_d = S_PARITY;
                  tx_d    = par_q;
                end else begin
                  state_d = S_STOP1;
                  tx_d    = 1'b1;
                end
              end else begin
                bit_d   = bit_q + BW'(1);
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
              end
            end

            S_PARITY: begin
              state_d = S_STOP1;
              tx_d    = 1'b1;
            end

            S_STOP1: begin
              tx_d = 1'b1;
              if (stop2_q) begin
                state_d = S_STOP2;
              end else begin
                state_d = rd_req ? S_FETCH : S_IDLE;
              end
            end

            S_STOP2: begin
              tx_d    = 1'b1;
              state_d = rd_req ? S_FETCH : S_IDLE;
            end

            default: begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          endcase
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//   Bench for uart_tx_sched. A FIFO model feeds the DUT; a reference model
//   expands each fetched character into the expected per-clock line level,
//   busy and done values, and predicts every FIFO pop.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int DW = 16;
  localparam int W  = 8;

  // Kinds of expected clock: 0 start, 1 data, 2 parity, 3 stop, 4 idle, 5 fetch
  typedef struct packed {
    logic       tx;
    logic       done;
    logic [2:0] kind;
  } ent_t;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_tx_en = 1'b0;
  logic [DW-1:0] i_div = '0;
  logic          i_parity_en = 1'b0;
  logic          i_parity_odd = 1'b0;
  logic          i_stop2 = 1'b0;
  logic          i_fifo_empty = 1'b1;
  logic [W-1:0]  i_fifo_data = '0;
  logic          o_fifo_rd_req;
  logic          o_tx;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  uart_tx_sched #(.DIV_WIDTH(DW), .DATA_WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_tx_en       (i_tx_en),
    .i_div         (i_div),
    .i_parity_en   (i_parity_en),
    .i_parity_odd  (i_parity_odd),
    .i_stop2       (i_stop2),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_data   (i_fifo_data),
    .o_fifo_rd_req (o_fifo_rd_req),
    .o_tx          (o_tx),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ent_t         expq[$];
  logic [W-1:0] fifo_q[$];
  bit           m_fetch = 1'b0;
  int           cur_kind = 4;
  bit           armed = 1'b0;
  int unsigned  done_cnt = 0;
  int unsigned  rd_cnt = 0;
  int unsigned  busy_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand the character now on the FIFO data port into per-clock entries
  // using the configuration presented during the FETCH clock.
  task automatic build_frame();
    logic bits[$];
    int   kinds[$];
    bits.push_back(1'b0); kinds.push_back(0);
    for (int i = 0; i < W; i++) begin
      bits.push_back(i_fifo_data[i]); kinds.push_back(1);
    end
    if (i_parity_en) begin
      bits.push_back((^i_fifo_data) ^ i_parity_odd); kinds.push_back(2);
    end
    bits.push_back(1'b1); kinds.push_back(3);
    if (i_stop2) begin
      bits.push_back(1'b1); kinds.push_back(3);
    end
    for (int j = 0; j < bits.size(); j++) begin
      for (int c = 0; c <= int'(i_div); c++) begin
        ent_t e;
        e.tx   = bits[j];
        e.done = (j == bits.size() - 1) && (c == int'(i_div));
        e.kind = 3'(kinds[j]);
        expq.push_back(e);
      end
    end
  endtask

  task automatic push_char(input logic [W-1:0] d);
    fifo_q.push_back(d);
    i_fifo_empty = 1'b0;
  endtask

  // One clock: check at the falling edge, then advance the FIFO model.
  task automatic tick();
    logic exp_rd, exp_tx, exp_busy, exp_done, rd_obs;
    ent_t e;
    @(negedge clk);
    if (m_fetch) begin
      exp_tx = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; exp_rd = 1'b0;
      cur_kind = 5;
      build_frame();
      m_fetch = 1'b0;
    end else if (expq.size() > 0) begin
      e = expq.pop_front();
      exp_tx = e.tx; exp_busy = 1'b1; exp_done = e.done;
      exp_rd = e.done && i_tx_en && !i_fifo_empty && !i_rst;
      cur_kind = int'(e.kind);
    end else begin
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      exp_rd = i_tx_en && !i_fifo_empty && !i_rst;
      cur_kind = 4;
    end
    if (armed) begin
      check_eq("tx", 32'(o_tx), 32'(exp_tx));
      check_eq("busy", 32'(o_busy), 32'(exp_busy));
      check_eq("done", 32'(o_done), 32'(exp_done));
      check_eq("rd_req", 32'(o_fifo_rd_req), 32'(exp_rd));
    end
    if (exp_rd) m_fetch = 1'b1;
    if (i_rst) begin
      expq.delete();
      m_fetch = 1'b0;
      cur_kind = 4;
      armed = 1'b1;
    end
    rd_obs = o_fifo_rd_req;
    if (o_done === 1'b1) done_cnt++;
    if (rd_obs === 1'b1) rd_cnt++;
    if (o_busy === 1'b1) busy_cnt++;
    @(posedge clk);
    #1;
    if (rd_obs === 1'b1 && fifo_q.size() > 0) i_fifo_data = fifo_q.pop_front();
    i_fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_kind(input int k, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (cur_kind != k && n < budget);
    if (cur_kind != k) check_eq("wait_kind_timeout", 32'(cur_kind), 32'(k));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bit idle;
    do begin
      tick();
      n++;
      idle = (cur_kind == 4) && !m_fetch && (fifo_q.size() == 0 || !i_tx_en);
    end while (!idle && n < budget);
    if (!idle) check_eq("wait_idle_timeout", 32'(cur_kind), 32'd4);
  endtask

  task automatic set_cfg(input int div, input bit pe, input bit po, input bit s2);
    i_div = DW'(div);
    i_parity_en = pe;
    i_parity_odd = po;
    i_stop2 = s2;
  endtask

  task automatic clear_counts();
    done_cnt = 0; rd_cnt = 0; busy_cnt = 0;
  endtask

  initial begin
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    tick();

    // 0xA5, div=3, even parity, one stop: 44-clock frame plus FETCH
    clear_counts();
    set_cfg(3, 1, 0, 0);
    i_tx_en = 1'b1;
    push_char(8'hA5);
    wait_idle(200);
    check_eq("a5_done_cnt", done_cnt, 1);
    check_eq("a5_busy_clocks", busy_cnt, 45);

    // 0x00, div=0, odd parity, two stops: 12 clocks
    clear_counts();
    set_cfg(0, 1, 1, 1);
    push_char(8'h00);
    wait_idle(100);
    check_eq("z_done_cnt", done_cnt, 1);
    check_eq("z_busy_clocks", busy_cnt, 13);

    // Three queued characters, div=1, no parity: back-to-back frames
    clear_counts();
    set_cfg(1, 0, 0, 0);
    push_char(8'h3C); push_char(8'hF0); push_char(8'h81);
    wait_idle(300);
    check_eq("b2b_rd_cnt", rd_cnt, 3);
    check_eq("b2b_done_cnt", done_cnt, 3);
    check_eq("b2b_busy_clocks", busy_cnt, 63);

    // Enable dropped during DATA of the first of two queued frames
    clear_counts();
    set_cfg(1, 1, 0, 0);
    push_char(8'h5A); push_char(8'h77);
    wait_kind(1, 50);
    i_tx_en = 1'b0;
    wait_idle(200);
    repeat (30) tick();
    check_eq("drop_rd_cnt", rd_cnt, 1);
    check_eq("drop_done_cnt", done_cnt, 1);
    fifo_q.delete();
    i_fifo_empty = 1'b1;
    tick();

    // Divisor changed from 3 to 7 mid-frame
    clear_counts();
    set_cfg(3, 0, 0, 0);
    i_tx_en = 1'b1;
    push_char(8'hC3);
    wait_kind(1, 50);
    i_div = DW'(7);
    push_char(8'h1E);
    wait_idle(400);
    check_eq("div_busy_clocks", busy_cnt, 122);
    check_eq("div_done_cnt", done_cnt, 2);

    // Reset for one clock during PARITY, FIFO empty afterwards
    clear_counts();
    set_cfg(3, 1, 0, 0);
    push_char(8'h96);
    wait_kind(2, 100);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    check_eq("rst_tx_after", 32'(o_tx), 32'd1);
    check_eq("rst_busy_after", 32'(o_busy), 32'd0);
    repeat (40) tick();
    check_eq("rst_done_cnt", done_cnt, 0);
    check_eq("rst_rd_cnt", rd_cnt, 1);

    // Randomised traffic with configuration churn and occasional resets
    i_tx_en = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 9) == 0 && fifo_q.size() < 4) push_char(W'($urandom));
      if ($urandom_range(0, 39) == 0) i_tx_en = ~i_tx_en;
      if ($urandom_range(0, 7) == 0)
        set_cfg($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
      i_rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    i_rst = 1'b0;
    i_tx_en = 1'b1;
    wait_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
